// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end for a single-ported data memory
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_rdata,
    output logic [31:0] rsp1_rdata,
    output logic        rsp0_err,
    output logic        rsp1_err,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    localparam logic [31:0] AMASK = 32'((64'd1 << ADDRESS_WIDTH) - 64'd1);

    state_t      state;
    logic        last, id_q, err_q, rsp_valid_q, rsp_err_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        idle, gnt1, accept, sel_err;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr, sel_wdata;

    // on a tie the requester that was not granted last wins
    assign idle       = rst_n && state == IDLE;
    assign gnt1       = req1_valid && (!req0_valid || !last);
    assign req0_ready = idle && req0_valid && !gnt1;
    assign req1_ready = idle && gnt1;
    assign accept     = req0_ready || req1_ready;
    assign sel_op     = gnt1 ? req1_op : req0_op;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_wdata  = gnt1 ? req1_wdata : req0_wdata;
    assign sel_err    = (sel_op inside {3'b100, 3'b101, 3'b111}) ||
                        (sel_op[2:1] == 2'b00 && sel_addr[1:0] != 2'b00);

    // the memory only sees the access during ISSUE; rejected ops never write
    assign mem_we = (state == ISSUE && !err_q) ? op_q : 3'b000;
    assign mem_a  = state == ISSUE ? addr_q : 32'd0;
    assign mem_wd = state == ISSUE ? wdata_q : 32'd0;

    assign rsp0_valid = rsp_valid_q && !id_q;
    assign rsp1_valid = rsp_valid_q && id_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : 32'd0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : 32'd0;
    assign rsp0_err   = rsp0_valid && rsp_err_q;
    assign rsp1_err   = rsp1_valid && rsp_err_q;

    // accept, issue, respond: one access every three cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state   <= ISSUE;
                    last    <= gnt1;
                    id_q    <= gnt1;
                    op_q    <= sel_op;
                    addr_q  <= sel_addr & AMASK;
                    wdata_q <= sel_wdata;
                    err_q   <= sel_err;
                end
                ISSUE: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rdata_q     <= (!err_q && !op_q[0]) ? mem_rd : 32'd0;
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rdata_q     <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter against a little-endian byte memory
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 3'b000, req1_op = 3'b000;
    logic [31:0] req0_addr = 32'd0, req1_addr = 32'd0;
    logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [2:0]  mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        clr = 1'b1;
    int          checks = 0, errors = 0;

    mem_arbiter #(.ADDRESS_WIDTH(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // data memory: 256 bytes, little-endian, async read, write on rising edge
    logic [7:0] mem [256];
    logic [7:0] wa, ba;
    logic [7:0] rb;
    logic [31:0] rw;
    always_comb begin
        wa = {mem_a[7:2], 2'b00};
        ba = mem_a[7:0];
        rb = mem[ba];
        rw = {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};
        mem_rd = mem_we == 3'b010 ? {{24{rb[7]}}, rb} : mem_we == 3'b110 ? {24'd0, rb} : rw;
    end
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (mem_we == 3'b001) begin
            mem[wa] <= mem_wd[7:0];
            mem[wa + 8'd1] <= mem_wd[15:8];
            mem[wa + 8'd2] <= mem_wd[23:16];
            mem[wa + 8'd3] <= mem_wd[31:24];
        end else if (mem_we == 3'b011) begin
            mem[ba] <= mem_wd[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit port, input logic v, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1_valid = v; req1_op = op; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = v; req0_op = op; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one complete access from a single requester, checked in every phase
    task automatic txn(input bit port, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err, input logic [2:0] exp_we);
        drive(port, 1'b1, op, addr, wdata);
        #1;
        chk("ready_owner", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
        chk("ready_other", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
        step();
        drive(port, 1'b0, 3'b000, 32'd0, 32'd0);
        chk("issue_we", {29'd0, mem_we}, {29'd0, exp_we});
        chk("issue_a", mem_a, addr & 32'h000F_FFFF);
        chk("issue_wd", mem_wd, wdata);
        chk("issue_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
        chk("rsp_rdata", port ? rsp1_rdata : rsp0_rdata, exp_rd);
        chk("rsp_err", {31'd0, port ? rsp1_err : rsp0_err}, {31'd0, exp_err});
        chk("resp_we", {29'd0, mem_we}, 32'd0);
        step();
        chk("idle_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    typedef struct {
        bit          port;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          err;
        logic [2:0]  we;
    } vec_t;
    vec_t vecs[15];

    initial begin
        vecs[0]  = '{0, 3'b001, 32'h10, 32'hAABBCCDD, 32'h0, 0, 3'b001};
        vecs[1]  = '{0, 3'b000, 32'h10, 32'h0, 32'hAABBCCDD, 0, 3'b000};
        vecs[2]  = '{1, 3'b011, 32'h21, 32'h000000F0, 32'h0, 0, 3'b011};
        vecs[3]  = '{1, 3'b010, 32'h21, 32'h0, 32'hFFFFFFF0, 0, 3'b010};
        vecs[4]  = '{1, 3'b110, 32'h21, 32'h0, 32'h000000F0, 0, 3'b110};
        vecs[5]  = '{0, 3'b000, 32'h13, 32'h0, 32'h0, 1, 3'b000};
        vecs[6]  = '{0, 3'b111, 32'h10, 32'h5, 32'h0, 1, 3'b000};
        vecs[7]  = '{1, 3'b001, 32'h22, 32'h12345678, 32'h0, 1, 3'b000};
        vecs[8]  = '{0, 3'b000, 32'h20, 32'h0, 32'h0000F000, 0, 3'b000};
        vecs[9]  = '{1, 3'b011, 32'h12, 32'h12345677, 32'h0, 0, 3'b011};
        vecs[10] = '{0, 3'b000, 32'h10, 32'h0, 32'hAA77CCDD, 0, 3'b000};
        vecs[11] = '{1, 3'b010, 32'h13, 32'h0, 32'hFFFFFFAA, 0, 3'b010};
        vecs[12] = '{0, 3'b100, 32'h10, 32'h0, 32'h0, 1, 3'b000};
        vecs[13] = '{1, 3'b101, 32'h10, 32'h0, 32'h0, 1, 3'b000};
        vecs[14] = '{0, 3'b000, 32'hFFF00010, 32'h0, 32'hAA77CCDD, 0, 3'b000};

        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset_rsp", {28'd0, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}, 32'd0);
        chk("reset_mem", {mem_we, mem_a[28:0]} | mem_wd, 32'd0);
        req0_valid = 1'b0;
        clr = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            txn(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].err, vecs[i].we);

        // reset in the middle of a store's ISSUE cycle aborts it
        drive(0, 1'b1, 3'b001, 32'h30, 32'h11223344);
        step();
        drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
        chk("abort_issue_we", {29'd0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", {29'd0, mem_we}, 32'd0);
        chk("abort_a", mem_a, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // both valid from reset: alternate 0,1,0,1
        drive(0, 1'b1, 3'b000, 32'h10, 32'h0);
        drive(1, 1'b1, 3'b000, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", {30'd0, req1_ready, req0_ready}, (k % 2) ? 32'd2 : 32'd1);
            step();
            chk("rr_issue_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
            chk("rr_rsp", {30'd0, rsp1_valid, rsp0_valid}, (k % 2) ? 32'd2 : 32'd1);
            chk("rr_rdata", (k % 2) ? rsp1_rdata : rsp0_rdata, (k % 2) ? 32'h0000F000 : 32'hAA77CCDD);
            step();
        end
        drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1, 1'b0, 3'b000, 32'd0, 32'd0);

        // req1 flickering valid while busy must not move the pointer
        drive(0, 1'b1, 3'b000, 32'h10, 32'h0);
        step();
        drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1, 1'b1, 3'b000, 32'h20, 32'h0);
        #1;
        chk("drop_ready", {31'd0, req1_ready}, 32'd0);
        drive(1, 1'b0, 3'b000, 32'd0, 32'd0);
        step();
        step();
        drive(0, 1'b1, 3'b000, 32'h10, 32'h0);
        drive(1, 1'b1, 3'b000, 32'h20, 32'h0);
        #1;
        chk("drop_tie_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        step();
        drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1, 1'b0, 3'b000, 32'd0, 32'd0);
        step();
        chk("drop_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        step();

        txn(0, 3'b000, 32'h30, 32'h0, 32'h0, 0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDRESS_WIDTH, 20, data memory address bits forwarded on mem_a.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n has an access pending.
REQ-005 Port: req0_ready / req1_ready  output  1  requester n is accepted this cycle.
REQ-006 Port: req0_op / req1_op  input  3  op code: 000 lw, 010 lb, 110 lbu, 001 sw, 011 sb.
REQ-007 Port: req0_addr / req1_addr  input  32  byte address.
REQ-008 Port: req0_wdata / req1_wdata  input  32  store data; sb uses bits [7:0].
REQ-009 Port: rsp0_valid / rsp1_valid  output  1  one-cycle response pulse to requester n.
REQ-010 Port: rsp0_rdata / rsp1_rdata  output  32  load result, valid while rsp_valid.
REQ-011 Port: rsp0_err / rsp1_err  output  1  access rejected, valid while rsp_valid.
REQ-012 Port: mem_we  output  3  op code driven to data memory write-enable/op input.
REQ-013 Port: mem_a  output  32  address to data memory; bits above ADDRESS_WIDTH-1 zero.
REQ-014 Port: mem_wd  output  32  store data to data memory.
REQ-015 Port: mem_rd  input  32  asynchronous read data from data memory.

Function
REQ-016 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE on accept, ISSUE->RESP always, RESP->IDLE always.
REQ-017 Accept: in IDLE, reqN_ready SHALL be 1 for exactly the granted requester with valid high; ready 0 in ISSUE and RESP.
REQ-018 Accept SHALL register op, addr, wdata and requester id; requester inputs are don't-care afterwards.
REQ-019 Arbitration: single requester valid -> it wins; both valid -> the one not granted last wins; last-grant pointer resets to 1 so port 0 wins first tie.
REQ-020 Outside ISSUE, mem_we SHALL be 000 (non-writing), mem_a and mem_wd 0.
REQ-021 In ISSUE, mem_we/mem_a/mem_wd SHALL carry the registered op/addr/wdata; stores commit at the ISSUE-ending edge.
REQ-022 At the ISSUE-ending edge the block SHALL capture mem_rd into the response data register for load ops; stores return rdata 0.
REQ-023 In RESP, rspN_valid SHALL pulse high one cycle for the owning requester only; no backpressure on responses.
REQ-024 Latency: accept at edge N, ISSUE in cycle N+1, response in N+2, next accept possible at edge N+3 (one access per 3 cycles max).
REQ-025 Error: op codes 100, 101, 111, or word op (000/001) with addr[1:0] != 00, SHALL set rsp_err=1, rdata=0, and keep mem_we=000 during ISSUE.
REQ-026 Address: mem_a SHALL equal {zeros, addr[ADDRESS_WIDTH-1:0]}; byte-alignment masking is left to the memory.
REQ-027 Requester dropping valid without ready SHALL not be granted and SHALL not move the last-grant pointer.
REQ-028 Last-grant pointer SHALL update only on accept.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, all ready/rsp_valid/rsp_err 0, rdata 0, mem_we 000, mem_a/mem_wd 0, pointer 1.
REQ-030 Reset during ISSUE SHALL abort the access: no store commits and no response is issued after release.
REQ-031 First accept possible at first rising edge after rst_n deasserts.

Verification
REQ-032 req0 sw addr 0x10 wdata 0xAABBCCDD, then req0 lw 0x10 -> two rsp0_valid pulses, second rdata matches memory word at 0x10 per memory byte order, err 0.
REQ-033 Both valid same cycle from reset, repeated 4 accesses -> grant order 0,1,0,1; each rsp only on owner.
REQ-034 req1 sb addr 0x21 wdata 0x000000F0, then lb 0x21 -> rdata 0xFFFFFFF0; lbu 0x21 -> 0x000000F0.
REQ-035 req0 lw addr 0x13 -> rsp0_err 1, rdata 0, mem_we 000 every cycle; op 111 same result.
REQ-036 rst_n pulsed low during ISSUE of sw 0x30 -> mem_we 000 immediately, memory at 0x30 unchanged, no rsp pulse after release.
